// File: rtl/magia_fsync_node.sv
// Two-child barrier node of the fractal sync tree: resolves barriers at NODE_LVL locally, forwards higher ones.
// Optional lone-child timeout is built only when MAGIA_FSYNC_TIMEOUT_EN is defined.

module magia_fsync_slot #(
    parameter int LVL_W    = 4,
    parameter int ID_W     = 8,
    parameter int NODE_LVL = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [LVL_W-1:0] lvl_i,
    input  logic [ID_W-1:0]  id_i,
    input  logic             open_i,
    input  logic             clr_i,
    output logic             acc_o,
    output logic             rej_o,
    output logic             vld_o,
    output logic [LVL_W-1:0] lvl_o,
    output logic [ID_W-1:0]  id_o
);
    assign acc_o = req_i && open_i && !vld_o && (lvl_i >= LVL_W'(NODE_LVL));
    assign rej_o = req_i && !acc_o;

    // clear wins over a same-cycle capture: a completing request never lingers in the slot
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_o <= 1'b0;
            lvl_o <= '0;
            id_o  <= '0;
        end else if (clr_i) begin
            vld_o <= 1'b0;
        end else if (acc_o) begin
            vld_o <= 1'b1;
            lvl_o <= lvl_i;
            id_o  <= id_i;
        end
    end
endmodule

module magia_fsync_node #(
    parameter int LVL_W       = 4,
    parameter int ID_W        = 8,
    parameter int NODE_LVL    = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [1:0]                 c_req_i,
    input  logic [1:0][LVL_W-1:0]      c_lvl_i,
    input  logic [1:0][ID_W-1:0]       c_id_i,
    output logic [1:0]                 c_wake_o,
    output logic [1:0]                 c_err_o,
    output logic                       up_req_o,
    output logic [LVL_W-1:0]           up_lvl_o,
    output logic [ID_W-1:0]            up_id_o,
    input  logic                       up_ack_i,
    input  logic                       up_wake_i
);
    typedef enum logic [1:0] {COLLECT, WAKE, FWD, WAIT_UP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             acc, rej, clr, err_d, err_q;
    logic [1:0]             slot_vld, eff_vld;
    logic [1:0][LVL_W-1:0]  slot_lvl, eff_lvl;
    logic [1:0][ID_W-1:0]   slot_id, eff_id;
    logic                   open, both, match, local_lvl, tmo;

    assign open = (state_q == COLLECT);

    for (genvar i = 0; i < 2; i++) begin : g_slot
        magia_fsync_slot #(.LVL_W(LVL_W), .ID_W(ID_W), .NODE_LVL(NODE_LVL)) u_slot (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .req_i  (c_req_i[i]),
            .lvl_i  (c_lvl_i[i]),
            .id_i   (c_id_i[i]),
            .open_i (open),
            .clr_i  (clr[i]),
            .acc_o  (acc[i]),
            .rej_o  (rej[i]),
            .vld_o  (slot_vld[i]),
            .lvl_o  (slot_lvl[i]),
            .id_o   (slot_id[i])
        );
        // a same-cycle arrival counts as if it were already in the slot
        assign eff_vld[i] = slot_vld[i] | acc[i];
        assign eff_lvl[i] = acc[i] ? c_lvl_i[i] : slot_lvl[i];
        assign eff_id[i]  = acc[i] ? c_id_i[i]  : slot_id[i];
    end

    assign both      = open && (&eff_vld);
    assign match     = (eff_id[0] == eff_id[1]) && (eff_lvl[0] == eff_lvl[1]);
    assign local_lvl = (eff_lvl[0] == LVL_W'(NODE_LVL));

`ifdef MAGIA_FSYNC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             lone;

    assign lone = open && (slot_vld[0] ^ slot_vld[1]) && !both;
    assign tmo  = lone && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)              cnt_q <= '0;
        else if (!lone || tmo)  cnt_q <= '0;
        else                    cnt_q <= cnt_q + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        clr     = 2'b00;
        err_d   = rej;
        case (state_q)
            COLLECT: begin
                if (both) begin
                    if (!match) begin
                        err_d = 2'b11;
                        clr   = 2'b11;
                    end else if (local_lvl) begin
                        state_d = WAKE;
                        clr     = 2'b11;
                    end else begin
                        state_d = FWD;
                    end
                end else if (tmo) begin
                    err_d = err_d | slot_vld;
                    clr   = slot_vld;
                end
            end
            WAKE: state_d = COLLECT;
            FWD: begin
                if (up_ack_i) begin
                    state_d = up_wake_i ? WAKE : WAIT_UP;
                    if (up_wake_i) clr = 2'b11;
                end
            end
            WAIT_UP: begin
                if (up_wake_i) begin
                    state_d = WAKE;
                    clr     = 2'b11;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= COLLECT;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // an error for a child suppresses its wake in the same cycle
    assign c_wake_o = {2{state_q == WAKE}} & ~err_q;
    assign c_err_o  = err_q;
    assign up_req_o = (state_q == FWD);
    assign up_lvl_o = up_req_o ? slot_lvl[0] : '0;
    assign up_id_o  = up_req_o ? slot_id[0]  : '0;
endmodule

// File: tb/tb_magia_fsync_node.sv
// Bench for magia_fsync_node: directed barrier scenarios with fixed expectations, then random traffic against a
// transaction-level model of pending children and the parent handshake.

module tb_magia_fsync_node;
    localparam int NODE = 1;
    localparam int TMO  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       c_req = '0;
    logic [1:0][3:0]  c_lvl = '0;
    logic [1:0][7:0]  c_id = '0;
    logic             up_ack = 1'b0, up_wake = 1'b0;
    logic [1:0]       c_wake, c_err;
    logic             up_req;
    logic [3:0]       up_lvl;
    logic [7:0]       up_id;

    int checks = 0;
    int errors = 0;

    magia_fsync_node #(.LVL_W(4), .ID_W(8), .NODE_LVL(NODE), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk), .rst_i(rst), .c_req_i(c_req), .c_lvl_i(c_lvl), .c_id_i(c_id),
        .c_wake_o(c_wake), .c_err_o(c_err), .up_req_o(up_req), .up_lvl_o(up_lvl), .up_id_o(up_id),
        .up_ack_i(up_ack), .up_wake_i(up_wake)
    );

    always #5 clk = ~clk;

    // reference model: which children wait, what went to the parent, what pulses are due
    bit [1:0]   m_pv;
    logic [3:0] m_pl [2];
    logic [7:0] m_pid [2];
    int         m_cap [2];
    bit         m_up_pend, m_up_wait, m_wake_st;
    bit [1:0]   m_err;
    logic [3:0] m_upl;
    logic [7:0] m_upi;
    int         m_edge = 0;

    task automatic model_reset();
        m_pv = '0; m_up_pend = 0; m_up_wait = 0; m_wake_st = 0; m_err = '0;
        m_upl = '0; m_upi = '0;
    endtask

    task automatic model_step();
        bit coll;
        bit [1:0] en;
        bit wn;
        coll = !m_up_pend && !m_up_wait && !m_wake_st;
        en = '0; wn = 0;
        if (m_up_pend && up_ack) begin
            m_up_pend = 0;
            if (up_wake) wn = 1; else m_up_wait = 1;
        end else if (m_up_wait && up_wake) begin
            m_up_wait = 0; wn = 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (c_req[i]) begin
                if (!coll || m_pv[i] || c_lvl[i] < 4'(NODE)) en[i] = 1;
                else begin
                    m_pv[i] = 1; m_pl[i] = c_lvl[i]; m_pid[i] = c_id[i]; m_cap[i] = m_edge + 1;
                end
            end
        end
        if (coll && m_pv == 2'b11) begin
            if (m_pid[0] == m_pid[1] && m_pl[0] == m_pl[1]) begin
                if (m_pl[0] == 4'(NODE)) wn = 1;
                else begin m_up_pend = 1; m_upl = m_pl[0]; m_upi = m_pid[0]; end
            end else en = 2'b11;
            m_pv = '0;
        end
`ifdef MAGIA_FSYNC_TIMEOUT_EN
        else if (coll && (m_pv[0] ^ m_pv[1])) begin
            for (int i = 0; i < 2; i++)
                if (m_pv[i] && m_edge + 1 == m_cap[i] + TMO) begin en[i] = 1; m_pv[i] = 0; end
        end
`endif
        m_wake_st = wn; m_err = en; m_edge++;
    endtask

    function automatic logic [16:0] exp_vec();
        return {({2{m_wake_st}} & ~m_err), m_err, m_up_pend,
                (m_up_pend ? m_upl : 4'd0), (m_up_pend ? m_upi : 8'd0)};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk); #1;
        c_req = '0; up_ack = 0; up_wake = 0;
    endtask

    task automatic req(input int ch, input int lvl, input int id);
        c_req[ch] = 1'b1; c_lvl[ch] = 4'(lvl); c_id[ch] = 8'(id);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({c_wake, c_err, up_req, up_lvl, up_id} !== 17'd0) begin
            errors++; $display("FAIL reset_hold: outs=%h exp=0", {c_wake, c_err, up_req, up_lvl, up_id});
        end
        rst = 0;
        tick();
        checks++;
        if ({c_wake, c_err, up_req, up_lvl, up_id} !== 17'd0) begin
            errors++; $display("FAIL reset_release: outs=%h exp=0", {c_wake, c_err, up_req, up_lvl, up_id});
        end
    endtask

    task automatic test_local_wake();
        logic [1:0] seen;
        seen = '0;
        req(0, 1, 5); tick();
        for (int i = 0; i < 3; i++) begin tick(); seen |= c_wake; end
        seen |= c_wake;
        req(1, 1, 5); tick();
        checks++;
        if (c_wake !== 2'b11 || c_err !== 2'b00 || seen !== 2'b00) begin
            errors++; $display("FAIL local_wake: wake=%b err=%b early=%b exp wake=11", c_wake, c_err, seen);
        end
        tick();
        checks++;
        if (c_wake !== 2'b00) begin errors++; $display("FAIL local_wake_once: wake=%b exp=00", c_wake); end
    endtask

    task automatic test_forward();
        req(0, 3, 9); req(1, 3, 9); tick();
        checks++;
        if (up_req !== 1'b1 || up_lvl !== 4'd3 || up_id !== 8'd9) begin
            errors++; $display("FAIL fwd_req: req=%b lvl=%0d id=%0d exp 1/3/9", up_req, up_lvl, up_id);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (up_req !== 1'b1 || up_lvl !== 4'd3 || up_id !== 8'd9) begin
            errors++; $display("FAIL fwd_hold: req=%b lvl=%0d id=%0d exp 1/3/9", up_req, up_lvl, up_id);
        end
        up_ack = 1; tick();
        checks++;
        if (up_req !== 1'b0) begin errors++; $display("FAIL fwd_ack: up_req=%b exp=0", up_req); end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (c_wake !== 2'b00) begin errors++; $display("FAIL fwd_early_wake: wake=%b exp=00", c_wake); end
        up_wake = 1; tick();
        checks++;
        if (c_wake !== 2'b11) begin errors++; $display("FAIL fwd_wake: wake=%b exp=11", c_wake); end
        tick();
    endtask

    task automatic test_ack_wake_same();
        req(0, 2, 4); req(1, 2, 4); tick();
        up_ack = 1; up_wake = 1; tick();
        checks++;
        if (c_wake !== 2'b11 || up_req !== 1'b0) begin
            errors++; $display("FAIL ack_wake_same: wake=%b up_req=%b exp 11/0", c_wake, up_req);
        end
        tick();
    endtask

    task automatic test_mismatch();
        req(0, 1, 2); tick();
        req(1, 1, 3); tick();
        checks++;
        if (c_err !== 2'b11 || c_wake !== 2'b00) begin
            errors++; $display("FAIL mismatch: err=%b wake=%b exp 11/00", c_err, c_wake);
        end
        // both slots must be empty: a fresh same-cycle pair completes cleanly
        req(0, 1, 4); req(1, 1, 4); tick();
        checks++;
        if (c_wake !== 2'b11 || c_err !== 2'b00) begin
            errors++; $display("FAIL mismatch_cleared: wake=%b err=%b exp 11/00", c_wake, c_err);
        end
        tick();
    endtask

    task automatic test_dup_and_low();
        req(1, 1, 7); tick();
        req(1, 1, 7); tick();
        checks++;
        if (c_err !== 2'b10) begin errors++; $display("FAIL dup_req: err=%b exp=10", c_err); end
        req(0, 0, 7); tick();
        checks++;
        if (c_err !== 2'b01 || c_wake !== 2'b00) begin
            errors++; $display("FAIL low_lvl: err=%b wake=%b exp 01/00", c_err, c_wake);
        end
        req(0, 1, 7); tick();
        checks++;
        if (c_wake !== 2'b11 || c_err !== 2'b00) begin
            errors++; $display("FAIL dup_complete: wake=%b err=%b exp 11/00", c_wake, c_err);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        req(0, 2, 6); req(1, 2, 6); tick();
        up_ack = 1; tick();
        #2 rst = 1; model_reset();
        #1;
        checks++;
        if ({c_wake, c_err, up_req, up_lvl, up_id} !== 17'd0) begin
            errors++; $display("FAIL rst_wait_async: outs=%h exp=0", {c_wake, c_err, up_req, up_lvl, up_id});
        end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        up_wake = 1; tick();
        checks++;
        if (c_wake !== 2'b00 || c_err !== 2'b00 || up_req !== 1'b0) begin
            errors++; $display("FAIL rst_wait_stale_wake: wake=%b err=%b req=%b exp 0", c_wake, c_err, up_req);
        end
        req(0, 1, 8); req(1, 1, 8); tick();
        checks++;
        if (c_wake !== 2'b11) begin errors++; $display("FAIL rst_wait_fresh: wake=%b exp=11", c_wake); end
        tick();
    endtask

    task automatic test_timeout();
        logic [1:0] seen;
        seen = '0;
        req(0, 1, 3); tick();
`ifdef MAGIA_FSYNC_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) begin tick(); seen |= c_err; end
        tick();
        checks++;
        if (c_err !== 2'b01 || seen !== 2'b00) begin
            errors++; $display("FAIL timeout: err=%b early=%b exp 01/00", c_err, seen);
        end
`else
        for (int i = 0; i < 1000; i++) begin tick(); seen |= c_err; end
        checks++;
        if (seen !== 2'b00) begin errors++; $display("FAIL no_timeout: err seen=%b exp=00", seen); end
        req(1, 1, 3); tick();
        checks++;
        if (c_wake !== 2'b11) begin errors++; $display("FAIL late_partner: wake=%b exp=11", c_wake); end
`endif
        tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 9) < 3) req(i, $urandom_range(0, 3), $urandom_range(0, 2));
            up_ack  = ($urandom_range(0, 1) == 1);
            up_wake = ($urandom_range(0, 4) == 0);
            tick();
            checks++;
            if ({c_wake, c_err, up_req, up_lvl, up_id} !== exp_vec()) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL random[%0d]: outs=%h exp=%h", n, {c_wake, c_err, up_req, up_lvl, up_id}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_local_wake();
        test_forward();
        test_ack_wake_same();
        test_mismatch();
        test_dup_and_low();
        test_reset_in_wait();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
